coinc_count_readout: RTL
========================

// Module: coinc_count_readout
// PURPOSE
//  Reader side of the coincidence detector's Counts interface: on a Start request, snapshots all NCOMB pair counters.
//  Streams them out one word per handshake over a valid/ready port, tagging each word with its channel pair.
//  Sits between the detector and the host/readout logic; the detector keeps counting during the transfer.
// PARAMETERS
//  NCHAN  4                   number of input channels
//  NBITS  4                   width of each pair count
//  NCOMB  NCHAN*(NCHAN-1)/2   number of channel pairs (derived; do not override)
// PORTS
//  Clk       in   1                  single clock, all logic on posedge
//  Rst_n     in   1                  asynchronous, active-low reset
//  Counts    in   NBITS x [NCOMB]    unpacked array of pair counts from detector, sampled on snapshot
//  Start     in   1                  snapshot+transfer request, single-cycle pulse
//  Ready     in   1                  downstream accepts current word
//  Valid     out  1                  Data/PairA/PairB/Last hold a valid word
//  Data      out  NBITS              count value (or checksum word)
//  PairA     out  $clog2(NCHAN)      lower channel index of pair
//  PairB     out  $clog2(NCHAN)      higher channel index of pair
//  Last      out  1                  current word is final word of frame
//  Busy      out  1                  frame in progress (snapshot held)
//  Missed    out  1                  one-cycle pulse: Start ignored because Busy
// BEHAVIOUR
//  Reset: Valid, Data, PairA, PairB, Last, Busy, Missed = 0; snapshot regs = 0; FSM = IDLE; async assert, sync release.
//  FSM IDLE -> SEND: Start=1 in IDLE; same edge copies Counts[0..NCOMB-1] into snapshot, word index k=0.
//  Latency: Valid=1 and Busy=1 the cycle after Start; Data=snap[0].
//  Handshake: transfer on posedge with Valid&&Ready; Valid, Data, PairA, PairB, Last stay stable until then.
//  Ready may be high before Valid; Ready low stalls indefinitely; no word dropped or repeated.
//  Pair order: k enumerates (0,1),(0,2)..(0,NCHAN-1),(1,2)..(NCHAN-2,NCHAN-1); PairA<PairB always.
//  Last=1 only on final word: k=NCOMB-1, or the checksum word if CHECKSUM_EN.
//  SEND -> IDLE: on handshake of Last word; Valid, Busy, Last drop next cycle; Data/PairA/PairB may hold last values.
//  Start while Busy, including the cycle the Last word handshakes: ignored; Missed=1 for the following cycle only.
//  Start is accepted again from the first cycle Busy=0 -> minimum 1 idle cycle between frames.
//  Counts changes after the snapshot do not affect the frame in progress; no saturation or arithmetic on counts.
//  Reset mid-frame: frame abandoned, all outputs to reset values, no partial Last.
// CONFIGURATION
//  CHECKSUM_EN defined: frame is NCOMB+1 words; extra word has Data = XOR of all snapshot counts.
//    Checksum word has PairA=PairB=0 and Last=1.
//  CHECKSUM_EN undefined: frame is NCOMB words; no checksum logic present.
// STRUCTURE
//  Shared package coinc_pkg:
//    NCOMB calc function; pair_a(k)/pair_b(k) index-to-pair functions, also used by detector and bench scoreboard.
//    readout state enum {IDLE, SEND}.
//  No sub-module: snapshot bank, index counter and FSM live in one module.
// TESTING (NCHAN=4, NBITS=4, NCOMB=6)
//  Counts={1,2,3,4,5,6} (k=0..5), Start, Ready=1 -> Valid next cycle; 6 consecutive words Data 1..6.
//    Pairs (0,1)(0,2)(0,3)(1,2)(1,3)(2,3); Last on 6th; Busy low after.
//  Same frame with Ready toggled 1,0,0,1,... -> identical word sequence; outputs frozen while Ready=0.
//  Counts changed to all 4'hF one cycle after Start -> frame still streams 1..6.
//  Start again at word 3 and on the Last handshake cycle -> Missed pulses once each; frame unaffected.
//  Rst_n low during word 2 -> all outputs 0 at once; next Start streams a full frame from k=0.
//  CHECKSUM_EN, Counts={1,2,3,4,5,6} -> 7th word Data=4'h7, PairA=PairB=0, Last=1; without macro Last on 6th word.

Source files
------------

// File: rtl/coinc_pkg.sv
// Shared definitions for the coincidence detector and its count readout:
// pair-count sizing, pair index mapping and the readout state type.
package coinc_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} rd_state_e;

    function automatic int ncomb_calc(input int nchan);
        return nchan * (nchan - 1) / 2;
    endfunction

    // Pairs are enumerated (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
    function automatic int pair_a(input int k, input int nchan);
        int r;
        int idx;
        r   = 0;
        idx = 0;
        for (int a = 0; a < nchan; a++) begin
            for (int b = a + 1; b < nchan; b++) begin
                if (idx == k) r = a;
                idx++;
            end
        end
        return r;
    endfunction

    function automatic int pair_b(input int k, input int nchan);
        int r;
        int idx;
        r   = 0;
        idx = 0;
        for (int a = 0; a < nchan; a++) begin
            for (int b = a + 1; b < nchan; b++) begin
                if (idx == k) r = b;
                idx++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/coinc_count_readout.sv
// Snapshots all pair counters on Start and streams them over a valid/ready port.
// Optional CHECKSUM_EN appends an XOR-of-all-counts word at the end of each frame.
module coinc_count_readout
    import coinc_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int NBITS = 4,
    localparam int NCOMB = ncomb_calc(NCHAN),
    localparam int PW    = $clog2(NCHAN)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [NBITS-1:0] Counts [NCOMB],
    input  logic             Start,
    input  logic             Ready,
    output logic             Valid,
    output logic [NBITS-1:0] Data,
    output logic [PW-1:0]    PairA,
    output logic [PW-1:0]    PairB,
    output logic             Last,
    output logic             Busy,
    output logic             Missed
);

`ifdef CHECKSUM_EN
    localparam int NWORDS = NCOMB + 1;
`else
    localparam int NWORDS = NCOMB;
`endif
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    rd_state_e        state_q, state_d;
    logic [NBITS-1:0] snap_q [NCOMB];
    logic [NBITS-1:0] snap_d [NCOMB];
    logic [KW-1:0]    k_q, k_d;
    logic             valid_q, valid_d;
    logic [NBITS-1:0] data_q, data_d;
    logic [PW-1:0]    pa_q, pa_d;
    logic [PW-1:0]    pb_q, pb_d;
    logic             last_q, last_d;
    logic             missed_q, missed_d;

`ifdef CHECKSUM_EN
    logic [NBITS-1:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < NCOMB; i++) csum = csum ^ snap_q[i];
    end
`endif

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        k_d      = k_q;
        valid_d  = valid_q;
        data_d   = data_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        last_d   = last_q;
        missed_d = Start && (state_q == SEND);
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = SEND;
                    snap_d  = Counts;
                    k_d     = '0;
                    valid_d = 1'b1;
                    data_d  = Counts[0];
                    pa_d    = PW'(pair_a(0, NCHAN));
                    pb_d    = PW'(pair_b(0, NCHAN));
                    last_d  = (NWORDS == 1);
                end
            end
            SEND: begin
                if (Ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        k_d    = k_q + 1'b1;
                        last_d = (k_d == KW'(NWORDS - 1));
                        if (int'(k_d) < NCOMB) begin
                            data_d = snap_q[k_d];
                            pa_d   = PW'(pair_a(int'(k_d), NCHAN));
                            pb_d   = PW'(pair_b(int'(k_d), NCHAN));
                        end
`ifdef CHECKSUM_EN
                        else begin
                            data_d = csum;
                            pa_d   = '0;
                            pb_d   = '0;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= IDLE;
            snap_q   <= '{default: '0};
            k_q      <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            pa_q     <= '0;
            pb_q     <= '0;
            last_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            k_q      <= k_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            last_q   <= last_d;
            missed_q <= missed_d;
        end
    end

    assign Valid  = valid_q;
    assign Data   = data_q;
    assign PairA  = pa_q;
    assign PairB  = pb_q;
    assign Last   = last_q;
    assign Busy   = (state_q == SEND);
    assign Missed = missed_q;

endmodule
